msp430_noc_link_arbiter: RTL and testbench

MSP430_NOC_LINK_ARBITER -- requirements
Module: msp430_noc_link_arbiter

---
 rtl/msp430_noc_arb_pkg.sv | 13 +
 rtl/msp430_rr_select.sv | 40 ++++
 rtl/msp430_noc_link_arbiter.sv | 132 +++++++++++++
 tb/tb_msp430_noc_link_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msp430_noc_arb_pkg.sv
// Shared types and constants for the NoC link arbiter.
// Counter logic in the top is enabled by macro MSP430_NOC_ARB_STATS_EN.
package msp430_noc_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int CNT_WIDTH          = 16;
    localparam int DEFAULT_FLIT_WIDTH = 32;

endpackage

// File: rtl/msp430_rr_select.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping modulo N, returned one-hot.
module msp430_rr_select #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] rot;
    logic [N-1:0] rot_gnt;

    // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
    assign rot_gnt = rot & (~rot + N'(1));

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [PW:0] fwd_idx;
            logic [PW:0] back_idx;

            always_comb begin
                fwd_idx = {1'b0, ptr} + (PW+1)'(gi);
                if (fwd_idx >= (PW+1)'(N)) begin
                    fwd_idx = fwd_idx - (PW+1)'(N);
                end
                back_idx = (PW+1)'(gi) + (PW+1)'(N) - {1'b0, ptr};
                if (back_idx >= (PW+1)'(N)) begin
                    back_idx = back_idx - (PW+1)'(N);
                end
            end

            assign rot[gi] = req[fwd_idx[PW-1:0]];
            assign gnt[gi] = rot_gnt[back_idx[PW-1:0]];
        end
    endgenerate

endmodule

// File: rtl/msp430_noc_link_arbiter.sv
// Packet-locked round-robin arbiter sharing one NoC link among CHANNELS requesters.
// Optional per-channel packet counters: define MSP430_NOC_ARB_STATS_EN.
module msp430_noc_link_arbiter
    import msp430_noc_arb_pkg::*;
#(
    parameter int FLIT_WIDTH = DEFAULT_FLIT_WIDTH,
    parameter int CHANNELS   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
    input  logic [CHANNELS-1:0]                  in_last,
    input  logic [CHANNELS-1:0]                  in_valid,
    output logic [CHANNELS-1:0]                  in_ready,
    output logic [FLIT_WIDTH-1:0]                out_flit,
    output logic                                 out_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [CHANNELS-1:0]                  grant,
    input  logic                                 stats_clr,
    output logic [CHANNELS-1:0][CNT_WIDTH-1:0]   pkt_count
);

    localparam int PW = $clog2(CHANNELS);

    arb_state_t          state_reg, state_next;
    logic [PW-1:0]       ptr_reg, ptr_next;
    logic [PW-1:0]       owner_reg, owner_next;
    logic [CHANNELS-1:0] rr_gnt;
    logic [PW-1:0]       owner;
    logic                has_owner;
    logic                xfer;
    logic                pkt_done;

    msp430_rr_select #(
        .N  (CHANNELS),
        .PW (PW)
    ) u_rr_select (
        .req (in_valid),
        .ptr (ptr_reg),
        .gnt (rr_gnt)
    );

    // In LOCKED the registered owner holds the link even while it idles.
    always_comb begin
        owner     = owner_reg;
        has_owner = 1'b1;
        if (state_reg == IDLE) begin
            owner     = '0;
            has_owner = |rr_gnt;
            for (int i = 0; i < CHANNELS; i++) begin
                if (rr_gnt[i]) begin
                    owner = PW'(i);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (has_owner) begin
            grant[owner] = 1'b1;
        end
        in_ready  = out_ready ? grant : '0;
        out_valid = has_owner && in_valid[owner];
        out_flit  = has_owner ? in_flit[owner] : '0;
        out_last  = has_owner && in_last[owner];
    end

    assign xfer     = out_valid && out_ready;
    assign pkt_done = xfer && out_last;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        case (state_reg)
            IDLE: begin
                if (xfer && !out_last) begin
                    state_next = LOCKED;
                    owner_next = owner;
                end
            end
            LOCKED: begin
                if (pkt_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (pkt_done) begin
            ptr_next = (owner == PW'(CHANNELS - 1)) ? '0 : owner + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
        end
    end

`ifdef MSP430_NOC_ARB_STATS_EN
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;

            // Clear has priority over a same-cycle completion; count saturates.
            always_ff @(posedge clk) begin
                if (rst || stats_clr) begin
                    cnt_reg <= '0;
                end else if (pkt_done && owner == PW'(gi) && cnt_reg != '1) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign pkt_count[gi] = cnt_reg;
        end
    endgenerate
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign pkt_count        = '0;
`endif

endmodule

// File: tb/tb_msp430_noc_link_arbiter.sv
// Self-checking bench: a 2-channel and a 4-channel arbiter checked every cycle
// against a behavioural model, plus directed scenarios with literal expectations.
module tb_msp430_noc_link_arbiter;

    localparam int FW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic out_ready = 1'b0;
    logic stats_clr = 1'b0;

    always #5 clk = ~clk;

    logic [1:0][FW-1:0] a_flit;
    logic [1:0]         a_last, a_valid, a_ready, a_grant;
    logic [FW-1:0]      a_oflit;
    logic               a_olast, a_ovalid;
    logic [1:0][15:0]   a_cnt;

    logic [3:0][FW-1:0] b_flit;
    logic [3:0]         b_last, b_valid, b_ready, b_grant;
    logic [FW-1:0]      b_oflit;
    logic               b_olast, b_ovalid;
    logic [3:0][15:0]   b_cnt;

    msp430_noc_link_arbiter #(.FLIT_WIDTH(FW), .CHANNELS(2)) dut_a (
        .clk(clk), .rst(rst), .in_flit(a_flit), .in_last(a_last), .in_valid(a_valid),
        .in_ready(a_ready), .out_flit(a_oflit), .out_last(a_olast), .out_valid(a_ovalid),
        .out_ready(out_ready), .grant(a_grant), .stats_clr(stats_clr), .pkt_count(a_cnt)
    );

    msp430_noc_link_arbiter #(.FLIT_WIDTH(FW), .CHANNELS(4)) dut_b (
        .clk(clk), .rst(rst), .in_flit(b_flit), .in_last(b_last), .in_valid(b_valid),
        .in_ready(b_ready), .out_flit(b_oflit), .out_last(b_olast), .out_valid(b_ovalid),
        .out_ready(out_ready), .grant(b_grant), .stats_clr(stats_clr), .pkt_count(b_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state, index 0 = 2-channel DUT, 1 = 4-channel DUT.
    bit m_locked[2];
    int m_owner[2];
    int m_ptr[2];
    int m_cnt[2][8];

    task automatic model_step(input int d, input int n,
                              input logic [7:0] v, input logic [7:0] l,
                              input logic [7:0][31:0] f,
                              input logic [7:0] g, input logic [7:0] rdy,
                              input logic [31:0] of, input logic ol, input logic ov,
                              input logic [7:0][15:0] pc);
        int         own;
        logic [2:0] oi;
        logic [7:0] eg;
        logic       ev;
        bit         done;
        own  = -1;
        done = 1'b0;
        if (m_locked[d]) begin
            own = m_owner[d];
        end else begin
            for (int k = 0; k < n; k++) begin
                if (own < 0 && v[3'((m_ptr[d] + k) % n)]) own = (m_ptr[d] + k) % n;
            end
        end
        oi = 3'(own);
        eg = '0;
        if (own >= 0) eg[oi] = 1'b1;
        ev = (own >= 0) && v[oi];
        chk($sformatf("dut%0d grant", d), 32'(g), 32'(eg));
        chk($sformatf("dut%0d in_ready", d), 32'(rdy), 32'(out_ready ? eg : 8'h00));
        chk($sformatf("dut%0d out_valid", d), 32'(ov), 32'(ev));
        chk($sformatf("dut%0d out_flit", d), of, (own >= 0) ? f[oi] : 32'h0);
        chk($sformatf("dut%0d out_last", d), 32'(ol), 32'((own >= 0) && l[oi]));
        for (int c = 0; c < n; c++) begin
            chk($sformatf("dut%0d pkt_count%0d", d, c), 32'(pc[3'(c)]), 32'(m_cnt[d][c]));
        end
        if (rst) begin
            m_locked[d] = 1'b0;
            m_ptr[d]    = 0;
            m_owner[d]  = 0;
            for (int c = 0; c < 8; c++) m_cnt[d][c] = 0;
        end else begin
            if (ev && out_ready) begin
                if (l[oi]) begin
                    done        = 1'b1;
                    m_locked[d] = 1'b0;
                    m_ptr[d]    = (own + 1) % n;
                end else begin
                    m_locked[d] = 1'b1;
                    m_owner[d]  = own;
                end
            end
`ifdef MSP430_NOC_ARB_STATS_EN
            if (stats_clr) begin
                for (int c = 0; c < 8; c++) m_cnt[d][c] = 0;
            end else if (done && m_cnt[d][own] < 65535) begin
                m_cnt[d][own]++;
            end
`endif
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            model_step(0, 2, {6'b0, a_valid}, {6'b0, a_last}, {192'b0, a_flit},
                       {6'b0, a_grant}, {6'b0, a_ready}, a_oflit, a_olast, a_ovalid,
                       {96'b0, a_cnt});
            model_step(1, 4, {4'b0, b_valid}, {4'b0, b_last}, {128'b0, b_flit},
                       {4'b0, b_grant}, {4'b0, b_ready}, b_oflit, b_olast, b_ovalid,
                       {64'b0, b_cnt});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        a_valid = '0;
        b_valid = '0;
        step();
        rst = 1'b0;
    endtask

    logic [3:0] e36[3] = '{4'h4, 4'h1, 4'h2};
    int         rem[4];
    int         seq[4];
    logic [3:0] acc;
    bit         prev_rst;

    initial begin
        int c0, c1, k, early;
        a_flit = '0; a_last = '0; a_valid = '0;
        b_flit = '0; b_last = '0; b_valid = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset grant", 32'(a_grant), 32'h0);
        chk("reset out_valid", 32'(a_ovalid), 32'h0);
        chk("reset in_ready", 32'(a_ready), 32'h0);
        chk("reset pkt_count", 32'(a_cnt), 32'h0);
        step();
        rst = 1'b0;

        // 3-flit ch0 packet, ch1 arrives at cycle 1 and must wait.
        for (int t = 0; t < 4; t++) begin
            a_valid   = {t >= 1, t < 3};
            a_flit[0] = 32'hA0 + 32'(t);
            a_last[0] = (t == 2);
            a_flit[1] = 32'hB0;
            a_last[1] = 1'b1;
            @(negedge clk);
            $display("r031 cycle %0d grant=%b flit=%h", t, a_grant, a_oflit);
            chk("r031 grant", 32'(a_grant), (t < 3) ? 32'h1 : 32'h2);
            chk("r031 flit", a_oflit, (t < 3) ? 32'hA0 + 32'(t) : 32'hB0);
            step();
        end
        a_valid = '0;

        // Two channels streaming single-flit packets alternate fairly.
        do_reset();
        c0 = 0;
        c1 = 0;
        a_valid = 2'b11; a_last = 2'b11;
        a_flit[0] = 32'h100; a_flit[1] = 32'h200;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            $display("r032 cycle %0d grant=%b", t, a_grant);
            chk("r032 grant", 32'(a_grant), (t % 2 == 0) ? 32'h1 : 32'h2);
            c0 += int'(a_ready[0]);
            c1 += int'(a_ready[1]);
            step();
        end
        chk("r032 ch0 transfers", 32'(c0), 32'd50);
        chk("r032 ch1 transfers", 32'(c1), 32'd50);
        a_valid = '0;

        // ch1 holds the link through a stalled 4-flit packet.
        do_reset();
        k = 0;
        early = 0;
        for (int t = 0; t < 16 && k < 4; t++) begin
            out_ready = (t % 2 == 0);
            a_valid   = {1'b1, t >= 1};
            a_flit[1] = 32'hC0 + 32'(k);
            a_last[1] = (k == 3);
            a_flit[0] = 32'hD0;
            a_last[0] = 1'b1;
            @(negedge clk);
            $display("r033 cycle %0d grant=%b ready=%b flit=%h", t, a_grant, a_ready, a_oflit);
            if (a_ready[0]) early++;
            if (a_ready[1]) begin
                chk("r033 ch1 flit", a_oflit, 32'hC0 + 32'(k));
                k++;
            end
            step();
        end
        chk("r033 ch1 flits delivered", 32'(k), 32'd4);
        chk("r033 ch0 held off", 32'(early), 32'd0);
        a_valid   = 2'b01;
        out_ready = 1'b1;
        @(negedge clk);
        chk("r033 ch0 granted after", 32'(a_grant), 32'h1);
        step();
        a_valid = '0;

        // Reset during flit 2 of a ch1 packet abandons it.
        do_reset();
        for (int t = 0; t < 4; t++) begin
            rst       = (t == 2);
            a_valid   = {1'b1, t >= 2};
            a_flit[1] = 32'hE0 + 32'(t);
            a_last[1] = 1'b0;
            a_flit[0] = 32'hF0;
            a_last[0] = 1'b1;
            @(negedge clk);
            $display("r034 cycle %0d rst=%b grant=%b", t, rst, a_grant);
            chk("r034 grant", 32'(a_grant), (t < 3) ? 32'h2 : 32'h1);
            step();
        end
        rst = 1'b0;
        a_valid = '0;

        // Four channels: pointer wraps from 3 back to ch0.
        do_reset();
        for (int c = 0; c < 4; c++) b_flit[c] = 32'h300 + 32'(c);
        b_last = 4'hF;
        for (int t = 0; t < 3; t++) begin
            b_valid = (t == 0) ? 4'b0100 : ((t == 1) ? 4'b0011 : 4'b0010);
            @(negedge clk);
            $display("r036 cycle %0d grant=%b", t, b_grant);
            chk("r036 grant", 32'(b_grant), 32'(e36[t]));
            step();
        end
        b_valid = '0;

        // Packet counters.
        do_reset();
        a_valid = 2'b01; a_last = 2'b01; a_flit[0] = 32'h55;
`ifdef MSP430_NOC_ARB_STATS_EN
        repeat (70000) step();
        @(negedge clk);
        chk("r035 saturated", 32'(a_cnt[0]), 32'h0000FFFF);
        step();
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        a_valid   = '0;
        @(negedge clk);
        $display("r035 after clear pkt_count0=%h", a_cnt[0]);
        chk("r035 clear wins", 32'(a_cnt[0]), 32'h0);
`else
        repeat (300) step();
        @(negedge clk);
        $display("r035 pkt_count=%h", a_cnt);
        chk("r035 counters absent", 32'(a_cnt), 32'h0);
`endif
        step();
        a_valid = '0;

        // Randomised traffic on the 4-channel arbiter, checked by the model.
        do_reset();
        acc      = '0;
        prev_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rem[c] = 0;
            seq[c] = 0;
        end
        for (int t = 0; t < 4000; t++) begin
            for (int c = 0; c < 4; c++) begin
                if (prev_rst) begin
                    b_valid[c] = 1'b0;
                    rem[c]     = 0;
                end else if (b_valid[c] && acc[c]) begin
                    seq[c]++;
                    rem[c]--;
                    if (rem[c] == 0) b_valid[c] = 1'b0;
                end
                if (!b_valid[c] && $urandom_range(0, 2) == 0) begin
                    rem[c]     = int'($urandom_range(1, 4));
                    b_valid[c] = 1'b1;
                end
                b_flit[c] = {8'(c), 24'(seq[c])};
                b_last[c] = (rem[c] == 1);
            end
            prev_rst  = rst;
            rst       = ($urandom_range(0, 499) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            stats_clr = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            acc = b_ready & b_valid;
            step();
        end
        rst = 1'b0;
        stats_clr = 1'b0;
        b_valid = '0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
